// File: rtl/dot_prod_pkg.sv
// Shared widths, latency and output narrowing for the streaming complex dot product.
// CPX_DOT_PROD_SAT_EN selects saturating narrowing; otherwise the value wraps.
package dot_prod_pkg;

    localparam int DOT_LATENCY = 4;
    localparam int WIDE_BITS   = 64;

    typedef struct packed {
        logic signed [WIDE_BITS-1:0] value;
        logic                        ovf;
    } sat_res_t;

    function automatic int sum_width(input int x_bits, input int y_bits, input int max_length);
        return x_bits + y_bits + 1 + $clog2(max_length);
    endfunction

    function automatic sat_res_t sat_trunc(input logic signed [WIDE_BITS-1:0] value, input int out_bits);
        sat_res_t res;
`ifdef CPX_DOT_PROD_SAT_EN
        logic signed [WIDE_BITS-1:0] hi;
        logic signed [WIDE_BITS-1:0] lo;
        hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_bits - 1));
        if (value > hi) begin
            res.value = hi;
            res.ovf   = 1'b1;
        end else if (value < lo) begin
            res.value = lo;
            res.ovf   = 1'b1;
        end else begin
            res.value = value;
            res.ovf   = 1'b0;
        end
`else
        // keep only the low out_bits, sign-extended back to full width
        res.value = (value <<< (WIDE_BITS - out_bits)) >>> (WIDE_BITS - out_bits);
        res.ovf   = 1'b0;
`endif
        return res;
    endfunction

endpackage

// File: rtl/cpx_mult_pip.sv
// Enable-gated complex multiplier: input register, four products, I/Q combine.
// conj selects x*conj(y); outputs are the registered combine stage.
module cpx_mult_pip #(
    parameter int a_bits = 12,
    parameter int b_bits = 12,
    localparam int PW = a_bits + b_bits,
    localparam int CW = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     conj,
    input  logic signed [a_bits-1:0] xi,
    input  logic signed [a_bits-1:0] xq,
    input  logic signed [b_bits-1:0] yi,
    input  logic signed [b_bits-1:0] yq,
    output logic signed [CW-1:0]     prod_i,
    output logic signed [CW-1:0]     prod_q
);

    logic signed [a_bits-1:0] xi_r, xq_r;
    logic signed [b_bits-1:0] yi_r, yq_r;
    logic                     conj1_r, conj2_r;
    logic signed [PW-1:0]     pii_r, pqq_r, pqi_r, piq_r;
    logic signed [CW-1:0]     pii_s, pqq_s, pqi_s, piq_s;
    logic signed [CW-1:0]     prod_i_r, prod_q_r;

    // sign-extend products to the combine width
    always_comb begin
        pii_s = CW'(pii_r);
        pqq_s = CW'(pqq_r);
        pqi_s = CW'(pqi_r);
        piq_s = CW'(piq_r);
    end

    // three register stages, all frozen while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xi_r     <= '0;
            xq_r     <= '0;
            yi_r     <= '0;
            yq_r     <= '0;
            conj1_r  <= 1'b0;
            pii_r    <= '0;
            pqq_r    <= '0;
            pqi_r    <= '0;
            piq_r    <= '0;
            conj2_r  <= 1'b0;
            prod_i_r <= '0;
            prod_q_r <= '0;
        end else if (en) begin
            xi_r     <= xi;
            xq_r     <= xq;
            yi_r     <= yi;
            yq_r     <= yq;
            conj1_r  <= conj;
            pii_r    <= PW'(xi_r) * PW'(yi_r);
            pqq_r    <= PW'(xq_r) * PW'(yq_r);
            pqi_r    <= PW'(xq_r) * PW'(yi_r);
            piq_r    <= PW'(xi_r) * PW'(yq_r);
            conj2_r  <= conj1_r;
            prod_i_r <= conj2_r ? (pii_s + pqq_s) : (pii_s - pqq_s);
            prod_q_r <= conj2_r ? (pqi_s - piq_s) : (pqi_s + piq_s);
        end
    end

    assign prod_i = prod_i_r;
    assign prod_q = prod_q_r;

endmodule

// File: rtl/cpx_dot_prod_stream.sv
// Streaming complex dot product with runtime length, optional conj(y) and a
// backpressured result port. Output narrowing follows CPX_DOT_PROD_SAT_EN.
module cpx_dot_prod_stream
    import dot_prod_pkg::*;
#(
    parameter int x_bits     = 12,
    parameter int y_bits     = 12,
    parameter int max_length = 256,
    parameter int out_bits   = 24,
    parameter int out_shift  = 0,
    localparam int LW = $clog2(max_length + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LW-1:0]              len,
    input  logic                       conj,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    input  logic signed [x_bits-1:0]   xi,
    input  logic signed [x_bits-1:0]   xq,
    input  logic signed [y_bits-1:0]   yi,
    input  logic signed [y_bits-1:0]   yq,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic signed [out_bits-1:0] i,
    output logic signed [out_bits-1:0] q,
    output logic                       ovf
);

    localparam int SW = sum_width(x_bits, y_bits, max_length);
    localparam int CW = x_bits + y_bits + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(max_length);

    logic                       adv_s, first_s, last_s, conj_s;
    logic [LW-1:0]              len_eff_s, cur_len_s, cnt_inc_s;
    logic [LW-1:0]              cnt_r, len_q_r;
    logic                       conj_q_r;
    logic [2:0]                 vld_r, first_r, last_r;
    logic signed [CW-1:0]       prod_i_s, prod_q_s;
    logic signed [SW-1:0]       prod_i_ext_s, prod_q_ext_s;
    logic signed [SW-1:0]       acc_i_r, acc_q_r;
    logic                       done_r;
    logic signed [WIDE_BITS-1:0] shift_i_s, shift_q_s;
    sat_res_t                   sat_i_s, sat_q_s;
    logic                       out_tvalid_r, ovf_r;
    logic signed [out_bits-1:0] i_r, q_r;
    logic                       unused_s;

    assign adv_s     = !out_tvalid_r || out_tready;
    assign in_tready = adv_s;

    // vector length clamp, first/last tagging and conj selection
    always_comb begin
        len_eff_s = len;
        if (len == {LW{1'b0}}) begin
            len_eff_s = LW'(32'd1);
        end else if (len > MAX_LEN) begin
            len_eff_s = MAX_LEN;
        end else begin
            len_eff_s = len;
        end
        first_s   = (cnt_r == {LW{1'b0}});
        cur_len_s = first_s ? len_eff_s : len_q_r;
        conj_s    = first_s ? conj : conj_q_r;
        cnt_inc_s = cnt_r + LW'(32'd1);
        last_s    = (cnt_inc_s == cur_len_s);
    end

    // sample counter; length and conj are latched on the first accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {LW{1'b0}};
            len_q_r  <= {LW{1'b0}};
            conj_q_r <= 1'b0;
        end else if (in_tvalid && adv_s) begin
            cnt_r <= last_s ? {LW{1'b0}} : cnt_inc_s;
            if (first_s) begin
                len_q_r  <= len_eff_s;
                conj_q_r <= conj;
            end
        end
    end

    // valid/first/last tags travel alongside the multiplier's three stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r   <= 3'b000;
            first_r <= 3'b000;
            last_r  <= 3'b000;
        end else if (adv_s) begin
            vld_r   <= {vld_r[1:0], in_tvalid};
            first_r <= {first_r[1:0], first_s};
            last_r  <= {last_r[1:0], last_s};
        end
    end

    cpx_mult_pip #(
        .a_bits (x_bits),
        .b_bits (y_bits)
    ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .en     (adv_s),
        .conj   (conj_s),
        .xi     (xi),
        .xq     (xq),
        .yi     (yi),
        .yq     (yq),
        .prod_i (prod_i_s),
        .prod_q (prod_q_s)
    );

    assign prod_i_ext_s = SW'(prod_i_s);
    assign prod_q_ext_s = SW'(prod_q_s);

    // a first sample reloads the accumulator, so vectors run back to back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i_r <= '0;
            acc_q_r <= '0;
            done_r  <= 1'b0;
        end else if (adv_s) begin
            done_r <= vld_r[2] && last_r[2];
            if (vld_r[2]) begin
                acc_i_r <= first_r[2] ? prod_i_ext_s : (acc_i_r + prod_i_ext_s);
                acc_q_r <= first_r[2] ? prod_q_ext_s : (acc_q_r + prod_q_ext_s);
            end
        end
    end

    assign shift_i_s = WIDE_BITS'(acc_i_r) >>> out_shift;
    assign shift_q_s = WIDE_BITS'(acc_q_r) >>> out_shift;
    assign sat_i_s   = sat_trunc(shift_i_s, out_bits);
    assign sat_q_s   = sat_trunc(shift_q_s, out_bits);
    assign unused_s  = ^{sat_i_s.value[WIDE_BITS-1:out_bits], sat_q_s.value[WIDE_BITS-1:out_bits]};

    // result register; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_tvalid_r <= 1'b0;
            i_r          <= '0;
            q_r          <= '0;
            ovf_r        <= 1'b0;
        end else if (adv_s) begin
            out_tvalid_r <= done_r;
            if (done_r) begin
                i_r   <= sat_i_s.value[out_bits-1:0];
                q_r   <= sat_q_s.value[out_bits-1:0];
                ovf_r <= sat_i_s.ovf | sat_q_s.ovf;
            end
        end
    end

    assign out_tvalid = out_tvalid_r;
    assign i          = i_r;
    assign q          = q_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_cpx_dot_prod_stream.sv
// Scoreboard bench for cpx_dot_prod_stream (max_length=8, out_bits=8).
// Expected results follow CPX_DOT_PROD_SAT_EN when it is defined.
module tb_cpx_dot_prod_stream;

    localparam int MAXL = 8;
    localparam int OB   = 8;

    logic                 clk;
    logic                 rst;
    logic [3:0]           len;
    logic                 conj;
    logic                 in_tvalid;
    logic                 in_tready;
    logic signed [11:0]   xi, xq, yi, yq;
    logic                 out_tvalid;
    logic                 out_tready;
    logic signed [OB-1:0] i, q;
    logic                 ovf;

    typedef struct {
        logic signed [OB-1:0] i;
        logic signed [OB-1:0] q;
        logic                 ovf;
    } exp_t;

    exp_t exp_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   xi_a[32], xq_a[32], yi_a[32], yq_a[32];
    bit   rand_on;

    cpx_dot_prod_stream #(
        .x_bits     (12),
        .y_bits     (12),
        .max_length (MAXL),
        .out_bits   (OB),
        .out_shift  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .len        (len),
        .conj       (conj),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .xi         (xi),
        .xq         (xq),
        .yi         (yi),
        .yq         (yq),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .i          (i),
        .q          (q),
        .ovf        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic signed [OB-1:0] fit(input longint v, output bit ov);
        longint t;
        t  = v;
        ov = 1'b0;
`ifdef CPX_DOT_PROD_SAT_EN
        if (t > 64'sd127) begin
            t  = 64'sd127;
            ov = 1'b1;
        end else if (t < -64'sd128) begin
            t  = -64'sd128;
            ov = 1'b1;
        end
`endif
        return t[OB-1:0];
    endfunction

    task automatic push_const(input int ei, input int eq, input bit eo);
        exp_t e;
        e.i   = ei[OB-1:0];
        e.q   = eq[OB-1:0];
        e.ovf = eo;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input int n, input bit cj, input int base);
        longint si, sq;
        bit     oi, oq;
        exp_t   e;
        si = 0;
        sq = 0;
        for (int k = base; k < base + n; k++) begin
            if (cj) begin
                si += xi_a[k] * yi_a[k] + xq_a[k] * yq_a[k];
                sq += xq_a[k] * yi_a[k] - xi_a[k] * yq_a[k];
            end else begin
                si += xi_a[k] * yi_a[k] - xq_a[k] * yq_a[k];
                sq += xq_a[k] * yi_a[k] + xi_a[k] * yq_a[k];
            end
        end
        e.i   = fit(si, oi);
        e.q   = fit(sq, oq);
        e.ovf = oi | oq;
        exp_q.push_back(e);
    endtask

    task automatic fill(input int base, input int n, input int a, input int b, input int c, input int d);
        for (int k = base; k < base + n; k++) begin
            xi_a[k] = a;
            xq_a[k] = b;
            yi_a[k] = c;
            yq_a[k] = d;
        end
    endtask

    task automatic fill_rand(input int base, input int n);
        for (int k = base; k < base + n; k++) begin
            xi_a[k] = int'($urandom_range(0, 15)) - 8;
            xq_a[k] = int'($urandom_range(0, 15)) - 8;
            yi_a[k] = int'($urandom_range(0, 15)) - 8;
            yq_a[k] = int'($urandom_range(0, 15)) - 8;
        end
    endtask

    task automatic drive_vec(input int len_v, input bit cj, input int n, input int base);
        for (int k = base; k < base + n; k++) begin
            int w;
            in_tvalid = 1'b1;
            len       = len_v[3:0];
            conj      = cj;
            xi        = 12'(xi_a[k]);
            xq        = 12'(xq_a[k]);
            yi        = 12'(yi_a[k]);
            yq        = 12'(yq_a[k]);
            w = 0;
            @(negedge clk);
            while (!in_tready && w < 300) begin
                w++;
                @(negedge clk);
            end
            if (w >= 300) check_eq("in_tready_timeout", 64'sd0, 64'sd1);
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_tvalid) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq(tag, exp_q.size(), 64'sd0);
    endtask

    // scoreboard: a result transfers on the edge following a negedge with valid && ready
    always @(negedge clk) begin
        if (!rst && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 64'sd1, 64'sd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("res_i", i, e.i);
                check_eq("res_q", q, e.q);
                check_eq("res_ovf", ovf, e.ovf);
            end
        end
    end

    initial begin
        int lat;
        logic signed [OB-1:0] hold_i, hold_q;
        rst        = 1'b1;
        len        = 4'd0;
        conj       = 1'b0;
        in_tvalid  = 1'b0;
        xi         = 12'sd0;
        xq         = 12'sd0;
        yi         = 12'sd0;
        yq         = 12'sd0;
        out_tready = 1'b1;
        rand_on    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_tvalid", out_tvalid, 64'sd0);
        check_eq("rst_in_tready", in_tready, 64'sd1);
        check_eq("rst_i", i, 64'sd0);
        check_eq("rst_q", q, 64'sd0);
        check_eq("rst_ovf", ovf, 64'sd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // len=5 of ones, with result latency
        fill(0, 5, 1, 0, 1, 0);
        push_const(5, 0, 1'b0);
        drive_vec(5, 1'b0, 5, 0);
        lat = 0;
        while (!out_tvalid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, 64'sd4);
        drain("drain_len5");

        // (1+2j)(3+4j) and its conjugate form, three times each
        fill(0, 3, 1, 2, 3, 4);
        push_const(-15, 30, 1'b0);
        drive_vec(3, 1'b0, 3, 0);
        push_const(33, 6, 1'b0);
        drive_vec(3, 1'b1, 3, 0);
        drain("drain_len3");

        // two back-to-back len=4 vectors, 3-cycle stall on the first result
        fill_rand(0, 8);
        push_model(4, 1'b0, 0);
        push_model(4, 1'b1, 4);
        fork
            begin
                drive_vec(4, 1'b0, 4, 0);
                drive_vec(4, 1'b1, 4, 4);
            end
            begin
                int w;
                w = 0;
                while (!out_tvalid && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check_eq("stall_wait", out_tvalid, 64'sd1);
                hold_i     = i;
                hold_q     = q;
                out_tready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_tready", in_tready, 64'sd0);
                    check_eq("stall_hold_i", i, hold_i);
                    check_eq("stall_hold_q", q, hold_q);
                end
                @(posedge clk);
                #1;
                out_tready = 1'b1;
            end
        join
        drain("drain_b2b");

        // len=0 behaves as 1; len above max_length clamps
        fill(0, 1, 3, 1, 2, -1);
        push_const(7, -1, 1'b0);
        drive_vec(0, 1'b0, 1, 0);
        fill_rand(0, 8);
        push_model(8, 1'b0, 0);
        drive_vec(MAXL + 5, 1'b0, 8, 0);
        drain("drain_len_edge");

        // 4 * 127^2 = 64516 exceeds 8 bits
        fill(0, 4, 127, 0, 127, 0);
`ifdef CPX_DOT_PROD_SAT_EN
        push_const(127, 0, 1'b1);
`else
        push_const(4, 0, 1'b0);
`endif
        drive_vec(4, 1'b0, 4, 0);
        drain("drain_ovf");

        // reset mid-vector discards the partial sum
        fill(0, 5, 9, 9, 9, 9);
        drive_vec(5, 1'b0, 2, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_out_tvalid", out_tvalid, 64'sd0);
        rst = 1'b0;
        fill(0, 5, 2, 0, 1, 1);
        push_const(10, 10, 1'b0);
        drive_vec(5, 1'b0, 5, 0);
        drain("drain_rst");

        // random vectors under random backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    int lv, ne;
                    bit cj;
                    lv = int'($urandom_range(0, 15));
                    ne = (lv == 0) ? 1 : ((lv > MAXL) ? MAXL : lv);
                    cj = 1'($urandom_range(0, 1));
                    fill_rand(0, ne);
                    push_model(ne, cj, 0);
                    drive_vec(lv, cj, ne, 0);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) out_tready = ($urandom_range(0, 3) != 0);
                end
                out_tready = 1'b1;
            end
        join
        drain("drain_rand");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
